// File: rtl/reg_core_lite_arbiter_if.sv
// AXI4-Lite link between reg_core_lite_arbiter (master side) and the reg_core register bank.
interface reg_core_lite_arbiter_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic [2:0]        M_AXI_AWPROT;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic [31:0]       M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [2:0]        M_AXI_ARPROT;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [31:0]       M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/reg_core_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite port to reg_core among NUM_REQ clients, one
// transaction in flight. Define REG_ARB_ADDR_CHECK_EN to reject bad addresses locally with SLVERR.
module reg_core_lite_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]       req_wdata,
    input  logic [NUM_REQ*4-1:0]        req_wstrb,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic [1:0]                  rsp_resp,
    reg_core_lite_arbiter_if.master     m_axi
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef REG_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD,
        S_RD_DATA,
        S_RSP
    } state_t;

    state_t              state_reg;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     id_reg;
    logic                awvalid_reg;
    logic                wvalid_reg;
    logic                bready_reg;
    logic                arvalid_reg;
    logic                rready_reg;
    logic [ADDR_W-1:0]   awaddr_reg;
    logic [ADDR_W-1:0]   araddr_reg;
    logic [31:0]         wdata_reg;
    logic [3:0]          wstrb_reg;
    logic [NUM_REQ-1:0]  rsp_valid_reg;
    logic [31:0]         rsp_rdata_reg;
    logic [1:0]          rsp_resp_reg;

    logic [ADDR_W-1:0]   cli_addr  [NUM_REQ];
    logic [31:0]         cli_wdata [NUM_REQ];
    logic [3:0]          cli_wstrb [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cli
            assign cli_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign cli_wdata[gi] = req_wdata[gi*32 +: 32];
            assign cli_wstrb[gi] = req_wstrb[gi*4 +: 4];
        end
    endgenerate

    // Scan from the farthest candidate to the nearest so the first valid index after the
    // pointer is the last one assigned.
    logic                grant_any;
    logic [ID_W-1:0]     grant_id;
    int                  cand_int;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand_int  = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand_int = int'(rr_ptr_reg) + off;
            if (cand_int >= NUM_REQ) begin
                cand_int = cand_int - NUM_REQ;
            end
            if (req_valid[ID_W'(cand_int)]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(cand_int);
            end
        end
    end

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

    logic                accept;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_we;
    logic                addr_bad;

    assign grant_onehot = id_onehot(grant_id);
    assign accept       = (state_reg == S_IDLE) && grant_any;
    assign req_ready    = accept ? grant_onehot : '0;
    assign sel_addr     = cli_addr[grant_id];
    assign sel_we       = req_we[grant_id];
    assign addr_bad     = (sel_addr[1:0] != 2'b00) ||
                          ({{(32-ADDR_W){1'b0}}, sel_addr} >= 32'(NUM_REGS * 4));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= ID_W'(NUM_REQ - 1);
            id_reg        <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            awaddr_reg    <= '0;
            araddr_reg    <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        rr_ptr_reg <= grant_id;
                        id_reg     <= grant_id;
                        if (ADDR_CHECK && addr_bad) begin
                            rsp_valid_reg <= grant_onehot;
                            rsp_rdata_reg <= '0;
                            rsp_resp_reg  <= RESP_SLVERR;
                            state_reg     <= S_RSP;
                        end else if (sel_we) begin
                            awaddr_reg  <= sel_addr;
                            wdata_reg   <= cli_wdata[grant_id];
                            wstrb_reg   <= cli_wstrb[grant_id];
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= S_WR;
                        end else begin
                            araddr_reg  <= sel_addr;
                            arvalid_reg <= 1'b1;
                            state_reg   <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    // AW and W retire independently; a finished channel stays low.
                    if (m_axi.M_AXI_AWREADY) begin
                        awvalid_reg <= 1'b0;
                    end
                    if (m_axi.M_AXI_WREADY) begin
                        wvalid_reg <= 1'b0;
                    end
                    if ((!awvalid_reg || m_axi.M_AXI_AWREADY) &&
                        (!wvalid_reg  || m_axi.M_AXI_WREADY)) begin
                        bready_reg <= 1'b1;
                        state_reg  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m_axi.M_AXI_BVALID) begin
                        bready_reg    <= 1'b0;
                        rsp_valid_reg <= id_onehot(id_reg);
                        rsp_rdata_reg <= '0;
                        rsp_resp_reg  <= m_axi.M_AXI_BRESP;
                        state_reg     <= S_RSP;
                    end
                end
                S_RD: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi.M_AXI_RVALID) begin
                        rready_reg    <= 1'b0;
                        rsp_valid_reg <= id_onehot(id_reg);
                        rsp_rdata_reg <= m_axi.M_AXI_RDATA;
                        rsp_resp_reg  <= m_axi.M_AXI_RRESP;
                        state_reg     <= S_RSP;
                    end
                end
                S_RSP: begin
                    rsp_valid_reg <= '0;
                    state_reg     <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;

    assign m_axi.M_AXI_AWADDR  = awaddr_reg;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_reg;
    assign m_axi.M_AXI_WDATA   = wdata_reg;
    assign m_axi.M_AXI_WSTRB   = wstrb_reg;
    assign m_axi.M_AXI_WVALID  = wvalid_reg;
    assign m_axi.M_AXI_BREADY  = bready_reg;
    assign m_axi.M_AXI_ARADDR  = araddr_reg;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_reg;
    assign m_axi.M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_reg_core_lite_arbiter.sv
// Directed bench for reg_core_lite_arbiter with a small reg_core slave model with
// programmable per-channel wait states and error injection.
`timescale 1ns/1ps
module tb_reg_core_lite_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 4;

    logic                      ACLK = 1'b0;
    logic                      ARESET = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_we = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*32-1:0]     req_wdata = '0;
    logic [NUM_REQ*4-1:0]      req_wstrb = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [31:0]               rsp_rdata;
    logic [1:0]                rsp_resp;

    int n_checks = 0;
    int n_errors = 0;

    reg_core_lite_arbiter_if #(.ADDR_W(ADDR_W)) axi ();

    reg_core_lite_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .req_valid(req_valid),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_resp (rsp_resp),
        .m_axi    (axi)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- slave model ----------------
    int   aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic b_err = 1'b0;
    int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [ADDR_W-1:0] s_awaddr = '0, s_araddr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] mem [4];

    logic aw_hs, w_hs;
    logic [ADDR_W-1:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;

    assign axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && (aw_cnt >= aw_wait);
    assign axi.M_AXI_WREADY  = axi.M_AXI_WVALID && (w_cnt >= w_wait);
    assign axi.M_AXI_BVALID  = b_pend && (b_cnt >= b_wait);
    assign axi.M_AXI_BRESP   = (axi.M_AXI_BVALID && b_err) ? 2'b10 : 2'b00;
    assign axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && (ar_cnt >= ar_wait);
    assign axi.M_AXI_RVALID  = r_pend && (r_cnt >= r_wait);
    assign axi.M_AXI_RDATA   = (axi.M_AXI_RVALID && s_araddr < 16) ? mem[s_araddr[3:2]] : 32'h0;
    assign axi.M_AXI_RRESP   = (axi.M_AXI_RVALID && s_araddr >= 16) ? 2'b10 : 2'b00;

    assign aw_hs = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
    assign w_hs  = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
    assign wa    = aw_hs ? axi.M_AXI_AWADDR : s_awaddr;
    assign wd    = w_hs ? axi.M_AXI_WDATA : s_wdata;
    assign ws    = w_hs ? axi.M_AXI_WSTRB : s_wstrb;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_cnt <= (axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.M_AXI_WVALID && !axi.M_AXI_WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            if (aw_hs) begin aw_got <= 1'b1; s_awaddr <= axi.M_AXI_AWADDR; end
            if (w_hs)  begin w_got <= 1'b1; s_wdata <= axi.M_AXI_WDATA; s_wstrb <= axi.M_AXI_WSTRB; end
            if (!b_pend && (aw_got || aw_hs) && (w_got || w_hs)) begin
                b_pend <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (!b_err && wa < 16) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ws[b]) mem[wa[3:2]][8*b +: 8] <= wd[8*b +: 8];
                    end
                end
            end
            if (b_pend) begin
                if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin b_pend <= 1'b0; b_cnt <= 0; end
                else b_cnt <= b_cnt + 1;
            end
            if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
                r_pend <= 1'b1; s_araddr <= axi.M_AXI_ARADDR;
            end
            if (r_pend) begin
                if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin r_pend <= 1'b0; r_cnt <= 0; end
                else r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- monitors ----------------
    int   cyc = 0, aw_rise = 0, w_rise = 0, ar_rise = 0;
    logic prev_aw = 1'b0, prev_w = 1'b0, prev_ar = 1'b0;

    always @(posedge ACLK) begin
        cyc     <= cyc + 1;
        prev_aw <= axi.M_AXI_AWVALID;
        prev_w  <= axi.M_AXI_WVALID;
        prev_ar <= axi.M_AXI_ARVALID;
        if (axi.M_AXI_AWVALID && !prev_aw) aw_rise <= aw_rise + 1;
        if (axi.M_AXI_WVALID && !prev_w)   w_rise  <= w_rise + 1;
        if (axi.M_AXI_ARVALID && !prev_ar) ar_rise <= ar_rise + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int c, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdat, input logic [3:0] strb);
        req_we[c]                     = we;
        req_addr[c*ADDR_W +: ADDR_W]  = addr;
        req_wdata[c*32 +: 32]         = wdat;
        req_wstrb[c*4 +: 4]           = strb;
        req_valid[c]                  = 1'b1;
    endtask

    task automatic wait_grant(input int c, output int gcyc);
        bit ok = 1'b0;
        gcyc = -1;
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if (req_ready[c]) ok = 1'b1;
            else @(negedge ACLK);
        end
        chk($sformatf("grant_c%0d", c), {31'b0, ok}, 32'd1);
        if (ok) begin
            chk($sformatf("grant_onehot_c%0d", c), {{(32-NUM_REQ){1'b0}}, req_ready}, 32'd1 << c);
            gcyc = cyc;
            @(posedge ACLK);
            #1;
        end
        req_valid[c] = 1'b0;
    endtask

    task automatic wait_rsp(input int c, input logic [31:0] exp_rd, input logic [1:0] exp_rs,
                            input int exp_lat);
        int lat = 0;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            @(negedge ACLK);
            if (rsp_valid != '0) lat = i;
        end
        chk($sformatf("rsp_latency_c%0d", c), lat, exp_lat);
        if (lat != 0) begin
            $display("rsp c%0d: rdata=0x%08h resp=%0d latency=%0d", c, rsp_rdata, rsp_resp, lat);
            chk("rsp_owner", {{(32-NUM_REQ){1'b0}}, rsp_valid}, 32'd1 << c);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, exp_rs});
            chk("ready_in_rsp", {{(32-NUM_REQ){1'b0}}, req_ready}, 32'd0);
            @(negedge ACLK);
            chk("rsp_pulse_len", {{(32-NUM_REQ){1'b0}}, rsp_valid}, 32'd0);
        end
    endtask

    task automatic xact(input int c, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wdat, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input logic [1:0] exp_rs, input int exp_lat);
        int g;
        drive_req(c, we, addr, wdat, strb);
        wait_grant(c, g);
        wait_rsp(c, exp_rd, exp_rs, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int g0, g1, a0, w0, r0;

        // reset state
        repeat (3) @(negedge ACLK);
        chk("rst_req_ready", {30'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_resp", {30'b0, rsp_resp}, 32'd0);
        chk("rst_valids", {29'b0, axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID}, 32'd0);
        chk("rst_readies", {30'b0, axi.M_AXI_BREADY, axi.M_AXI_RREADY}, 32'd0);
        chk("rst_addr", {22'b0, axi.M_AXI_AWADDR, axi.M_AXI_ARADDR}, 32'd0);
        chk("rst_wdata", axi.M_AXI_WDATA, 32'd0);
        chk("rst_prot", {26'b0, axi.M_AXI_AWPROT, axi.M_AXI_ARPROT}, 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // simultaneous requests, then round-robin alternation
        drive_req(0, 1'b1, 5'h04, 32'hA5A5_A5A5, 4'hF);
        drive_req(1, 1'b0, 5'h04, 32'h0, 4'h0);
        wait_grant(0, g0);
        wait_rsp(0, 32'h0, 2'b00, 3);
        wait_grant(1, g1);
        chk("grant_spacing", g1 - g0, 32'd4);
        wait_rsp(1, 32'hA5A5_A5A5, 2'b00, 3);
        drive_req(0, 1'b0, 5'h04, 32'h0, 4'h0);
        drive_req(1, 1'b1, 5'h08, 32'h5A5A_0001, 4'hF);
        wait_grant(0, g0);
        wait_rsp(0, 32'hA5A5_A5A5, 2'b00, 3);
        wait_grant(1, g1);
        wait_rsp(1, 32'h0, 2'b00, 3);

        // single client write then read back
        xact(0, 1'b1, 5'h00, 32'h0000_0001, 4'hF, 32'h0, 2'b00, 3);
        xact(0, 1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0001, 2'b00, 3);

        // W delayed five cycles, slave error response
        w_wait = 5; b_err = 1'b1;
        a0 = aw_rise; w0 = w_rise;
        xact(0, 1'b1, 5'h08, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b10, 8);
        chk("aw_single_assert", aw_rise - a0, 32'd1);
        chk("w_single_assert", w_rise - w0, 32'd1);
        w_wait = 0; b_err = 1'b0;
        xact(1, 1'b0, 5'h08, 32'h0, 4'h0, 32'h5A5A_0001, 2'b00, 3);

        // AW delayed behind W
        aw_wait = 3;
        xact(1, 1'b1, 5'h0C, 32'h0000_0777, 4'hF, 32'h0, 2'b00, 6);
        aw_wait = 0;

        // out-of-range and misaligned reads
        r0 = ar_rise;
`ifdef REG_ARB_ADDR_CHECK_EN
        xact(0, 1'b0, 5'h10, 32'h0, 4'h0, 32'h0, 2'b10, 1);
        xact(0, 1'b0, 5'h02, 32'h0, 4'h0, 32'h0, 2'b10, 1);
        chk("no_arvalid_on_bad_addr", ar_rise - r0, 32'd0);
`else
        drive_req(0, 1'b0, 5'h10, 32'h0, 4'h0);
        wait_grant(0, g0);
        chk("araddr_0x10", {27'b0, axi.M_AXI_ARADDR}, 32'h10);
        wait_rsp(0, 32'h0, 2'b10, 3);
        drive_req(0, 1'b0, 5'h02, 32'h0, 4'h0);
        wait_grant(0, g0);
        chk("araddr_0x02", {27'b0, axi.M_AXI_ARADDR}, 32'h02);
        wait_rsp(0, 32'h0000_0001, 2'b00, 3);
        chk("arvalid_on_bad_addr", ar_rise - r0, 32'd2);
`endif

        // asynchronous reset while waiting for read data
        r_wait = 20;
        drive_req(1, 1'b0, 5'h04, 32'h0, 4'h0);
        wait_grant(1, g1);
        @(negedge ACLK);
        @(negedge ACLK);
        chk("rready_before_reset", {31'b0, axi.M_AXI_RREADY}, 32'd1);
        #1 ARESET = 1'b1;
        #1;
        chk("arst_rready", {31'b0, axi.M_AXI_RREADY}, 32'd0);
        chk("arst_araddr", {27'b0, axi.M_AXI_ARADDR}, 32'd0);
        chk("arst_rsp_rdata", rsp_rdata, 32'd0);
        chk("arst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        r_wait = 0;
        drive_req(0, 1'b0, 5'h04, 32'h0, 4'h0);
        drive_req(1, 1'b0, 5'h08, 32'h0, 4'h0);
        wait_grant(0, g0);
        wait_rsp(0, 32'hA5A5_A5A5, 2'b00, 3);
        wait_grant(1, g1);
        wait_rsp(1, 32'h5A5A_0001, 2'b00, 3);

        // fill all registers from alternating clients and read them back
        xact(0, 1'b1, 5'h00, 32'd1, 4'hF, 32'h0, 2'b00, 3);
        xact(1, 1'b1, 5'h04, 32'd2, 4'hF, 32'h0, 2'b00, 3);
        xact(0, 1'b1, 5'h08, 32'd3, 4'hF, 32'h0, 2'b00, 3);
        xact(1, 1'b1, 5'h0C, 32'd4, 4'hF, 32'h0, 2'b00, 3);
        xact(1, 1'b0, 5'h00, 32'h0, 4'h0, 32'd1, 2'b00, 3);
        xact(0, 1'b0, 5'h04, 32'h0, 4'h0, 32'd2, 2'b00, 3);
        xact(1, 1'b0, 5'h08, 32'h0, 4'h0, 32'd3, 2'b00, 3);
        xact(0, 1'b0, 5'h0C, 32'h0, 4'h0, 32'd4, 2'b00, 3);

        // partial strobes reach the slave untouched
        xact(0, 1'b1, 5'h0C, 32'hAABB_CCDD, 4'b0011, 32'h0, 2'b00, 3);
        xact(1, 1'b0, 5'h0C, 32'h0, 4'h0, 32'h0000_CCDD, 2'b00, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
